calc_port_driver: RTL and testbench
===================================

CALC_PORT_DRIVER -- requirements
Module: calc_port_driver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 10, the number of WAIT_RESP cycles allowed before a timeout (used only with CALC_DRV_TIMEOUT_EN).
REQ-002 SHALL have port c_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, upstream request valid.
REQ-005 SHALL have port in_ready, output, 1, driver accepts a request.
REQ-006 SHALL have port in_cmd, input, 4, calculator command.
REQ-007 SHALL have port in_op1, input, 32, operand 1.
REQ-008 SHALL have port in_op2, input, 32, operand 2.
REQ-009 SHALL have port req_cmd_out, output, 4, which drives the calculator reqN_cmd_in.
REQ-010 SHALL have port req_data_out, output, 32, which drives the calculator reqN_data_in.
REQ-011 SHALL have port out_resp, input, 2, from the calculator out_respN.
REQ-012 SHALL have port out_data, input, 32, from the calculator out_dataN.
REQ-013 SHALL have port rsp_valid, output, 1, result valid.
REQ-014 SHALL have port rsp_ready, input, 1, downstream accepts the result.
REQ-015 SHALL have port rsp_resp, output, 2, captured response code.
REQ-016 SHALL have port rsp_data, output, 32, captured result data.
REQ-017 SHALL have port rsp_timeout, output, 1, result produced by timeout.

Function
REQ-018 SHALL implement the state machine IDLE, SEND_OP1, SEND_OP2, WAIT_RESP, HOLD_RSP, with every state other than IDLE able to return to IDLE only via HOLD_RSP or reset.
REQ-019 SHALL assert in_ready only in IDLE, and on in_valid&&in_ready SHALL capture in_cmd/in_op1/in_op2 and enter SEND_OP1 on the next cycle.
REQ-020 SHALL drive req_cmd_out=cmd and req_data_out=op1 in SEND_OP1 (cycle N+1 after accept cycle N).
REQ-021 SHALL drive req_cmd_out=0 and req_data_out=op2 in SEND_OP2 (cycle N+2).
REQ-022 SHALL drive req_cmd_out=0 and req_data_out=0 in all other states.
REQ-023 SHALL go SEND_OP2 -> HOLD_RSP directly when cmd==0 (no-op), with rsp_resp=0 and rsp_data=0, because the calculator gives no response.
REQ-024 SHALL otherwise go SEND_OP2 -> WAIT_RESP.
REQ-025 SHALL, in WAIT_RESP, on the first cycle with out_resp!=0, capture out_resp/out_data and enter HOLD_RSP on the next cycle.
REQ-026 SHALL ignore out_resp in every state except WAIT_RESP.
REQ-027 SHALL assert rsp_valid only in HOLD_RSP and hold rsp_resp/rsp_data/rsp_timeout stable there until rsp_valid&&rsp_ready, then return to IDLE.
REQ-028 SHALL therefore accept the next request no earlier than the cycle after the result handshake (one outstanding transaction).
REQ-029 SHALL pass rsp_resp values through unmodified: 1=ok, 2=overflow/underflow, 3=invalid command.

Reset
REQ-030 SHALL, while reset is high at a clock edge, enter IDLE and discard any in-flight transaction, including one in WAIT_RESP or HOLD_RSP.
REQ-031 SHALL set these values after reset: in_ready=1, rsp_valid=0, req_cmd_out=0, req_data_out=0, rsp_resp=0, rsp_data=0, rsp_timeout=0, timeout counter=0.

Configuration
REQ-032 SHALL, with CALC_DRV_TIMEOUT_EN defined, count cycles in WAIT_RESP and, after TIMEOUT_CYCLES cycles without a response, enter HOLD_RSP with rsp_resp=0, rsp_data=0, rsp_timeout=1.
REQ-033 SHALL, when a response arrives on the same cycle the limit is reached, take the response (rsp_timeout=0).
REQ-034 SHALL, without CALC_DRV_TIMEOUT_EN, wait in WAIT_RESP indefinitely, tie rsp_timeout to 0, and instantiate no counter.

Structure
REQ-035 SHALL place in shared package calc_drv_pkg: the state enum; the command constants CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6; and the response constants RESP_NONE=0, RESP_OK=1, RESP_ERR=2, RESP_INV=3.
REQ-036 SHALL implement the timeout counter as sub-module calc_drv_timer (clear, enable, expired), instantiated only under CALC_DRV_TIMEOUT_EN.

Verification
REQ-037 SHALL check: accept cmd=1, op1=0x5, op2=0x1; calculator stub answers resp=1, data=0x6 on the 3rd WAIT_RESP cycle -> req bus shows (1,0x5),(0,0x1), then rsp_valid with 1/0x6.
REQ-038 SHALL check: cmd=0, op1=0x64, op2=0x27 -> no WAIT_RESP, rsp_valid at N+3 with rsp_resp=0, rsp_data=0.
REQ-039 SHALL check: cmd=1, op1=0xFFFFFFFF, op2=0x1; stub answers resp=2 -> rsp_resp=2, rsp_timeout=0.
REQ-040 SHALL check: rsp_ready held low 5 cycles -> result stable and in_ready=0 throughout; a second request is accepted the cycle after the handshake.
REQ-041 SHALL check, with CALC_DRV_TIMEOUT_EN and TIMEOUT_CYCLES=10, a stub that never answers -> rsp_timeout=1 after exactly 10 WAIT_RESP cycles; without the macro the driver remains in WAIT_RESP after 50 cycles.
REQ-042 SHALL check: reset pulsed during WAIT_RESP -> IDLE on the next cycle with all outputs at their reset values, and no rsp_valid for the discarded transaction.

Source files
------------

// File: rtl/calc_drv_pkg.sv
// Shared types and constants for the calculator port driver.
package calc_drv_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSendOp1,
        StSendOp2,
        StWaitResp,
        StHoldRsp
    } drv_state_e;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;
    localparam logic [1:0] RESP_INV  = 2'd3;

endpackage

// File: rtl/calc_drv_timer.sv
// WAIT_RESP cycle counter. expired is high during the TIMEOUT_CYCLES-th enabled cycle.
// Only instantiated when CALC_DRV_TIMEOUT_EN is defined.
module calc_drv_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 10
) (
    input  logic c_clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] count_q;

    assign expired = enable && (count_q == Limit);

    // Count enabled cycles, saturating at the limit; clear whenever not waiting.
    always_ff @(posedge c_clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + CntW'(1);
        end
    end

endmodule

// File: rtl/calc_port_driver.sv
// Drives one calculator request port: accepts a command with two operands, serialises it
// onto the req bus over two cycles, waits for the response and holds it until taken.
// Optional WAIT_RESP timeout enabled by defining CALC_DRV_TIMEOUT_EN.
module calc_port_driver
    import calc_drv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 10
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_cmd,
    input  logic [31:0] in_op1,
    input  logic [31:0] in_op2,
    output logic [3:0]  req_cmd_out,
    output logic [31:0] req_data_out,
    input  logic [1:0]  out_resp,
    input  logic [31:0] out_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_resp,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout
);

    drv_state_e  state_q, state_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [1:0]  resp_q, resp_d;
    logic [31:0] data_q, data_d;
    logic        timed_out;

`ifdef CALC_DRV_TIMEOUT_EN
    logic timeout_q, timeout_d;
    logic wait_active;

    assign wait_active = (state_q == StWaitResp);

    calc_drv_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .c_clk  (c_clk),
        .reset  (reset),
        .clear  (!wait_active),
        .enable (wait_active),
        .expired(timed_out)
    );

    assign rsp_timeout = timeout_q;
`else
    assign timed_out   = 1'b0;
    assign rsp_timeout = 1'b0;

    // The limit only matters with the timer built in.
    if (TIMEOUT_CYCLES == 0) begin : g_no_timer_cfg
    end
`endif

    assign rsp_resp = resp_q;
    assign rsp_data = data_q;

    // Next-state, capture and req/handshake outputs.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        resp_d       = resp_q;
        data_d       = data_q;
`ifdef CALC_DRV_TIMEOUT_EN
        timeout_d    = timeout_q;
`endif
        in_ready     = 1'b0;
        rsp_valid    = 1'b0;
        req_cmd_out  = CMD_NOP;
        req_data_out = '0;

        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cmd_d   = in_cmd;
                    op1_d   = in_op1;
                    op2_d   = in_op2;
                    state_d = StSendOp1;
                end
            end
            StSendOp1: begin
                req_cmd_out  = cmd_q;
                req_data_out = op1_q;
                state_d      = StSendOp2;
            end
            StSendOp2: begin
                req_data_out = op2_q;
                // The calculator never answers a no-op, so synthesise an empty result.
                if (cmd_q == CMD_NOP) begin
                    resp_d    = RESP_NONE;
                    data_d    = '0;
`ifdef CALC_DRV_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d   = StHoldRsp;
                end else begin
                    state_d = StWaitResp;
                end
            end
            StWaitResp: begin
                // A response on the limit cycle wins over the timeout.
                if (out_resp != RESP_NONE) begin
                    resp_d    = out_resp;
                    data_d    = out_data;
`ifdef CALC_DRV_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d   = StHoldRsp;
                end else if (timed_out) begin
                    resp_d    = RESP_NONE;
                    data_d    = '0;
`ifdef CALC_DRV_TIMEOUT_EN
                    timeout_d = 1'b1;
`endif
                    state_d   = StHoldRsp;
                end
            end
            StHoldRsp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and capture registers; reset discards any in-flight transaction.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cmd_q     <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            resp_q    <= '0;
            data_q    <= '0;
`ifdef CALC_DRV_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            resp_q    <= resp_d;
            data_q    <= data_d;
`ifdef CALC_DRV_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_calc_port_driver.sv
// Self-checking bench for calc_port_driver with a calculator stub and a behavioural
// calculator model. Honours CALC_DRV_TIMEOUT_EN the same way the design does.
module tb_calc_port_driver;
    import calc_drv_pkg::*;

    localparam int unsigned TMO = 10;
`ifdef CALC_DRV_TIMEOUT_EN
    localparam bit TimeoutOn = 1'b1;
`else
    localparam bit TimeoutOn = 1'b0;
`endif

    logic        c_clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cmd;
    logic [31:0] in_op1;
    logic [31:0] in_op2;
    logic [3:0]  req_cmd_out;
    logic [31:0] req_data_out;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_data;
    logic        rsp_timeout;

    int vectors = 0;
    int miscompares = 0;

    calc_port_driver #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_cmd      (in_cmd),
        .in_op1      (in_op1),
        .in_op2      (in_op2),
        .req_cmd_out (req_cmd_out),
        .req_data_out(req_data_out),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_resp    (rsp_resp),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout)
    );

    always #5 c_clk = ~c_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // What a well-behaved calculator answers for a command.
    task automatic calc_model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                              output logic [1:0] resp, output logic [31:0] data);
        logic [32:0] wide;
        case (cmd)
            CMD_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                resp = wide[32] ? RESP_ERR : RESP_OK;
                data = wide[32] ? 32'd0 : wide[31:0];
            end
            CMD_SUB: begin
                resp = (a < b) ? RESP_ERR : RESP_OK;
                data = (a < b) ? 32'd0 : a - b;
            end
            CMD_SHL: begin
                resp = RESP_OK;
                data = a << b[4:0];
            end
            CMD_SHR: begin
                resp = RESP_OK;
                data = a >> b[4:0];
            end
            default: begin
                resp = RESP_INV;
                data = 32'd0;
            end
        endcase
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_in_ready"}, 64'(in_ready), 64'd1);
        check({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({pfx, "_req_cmd"}, 64'(req_cmd_out), 64'd0);
        check({pfx, "_req_data"}, 64'(req_data_out), 64'd0);
        check({pfx, "_rsp_resp"}, 64'(rsp_resp), 64'd0);
        check({pfx, "_rsp_data"}, 64'(rsp_data), 64'd0);
        check({pfx, "_rsp_timeout"}, 64'(rsp_timeout), 64'd0);
    endtask

    // One full transaction. delay = WAIT_RESP cycle on which the stub answers (0 = never).
    task automatic do_txn(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                          input int delay, input int hold);
        logic [1:0]  er;
        logic [31:0] ed;
        logic        et;
        int          waits;
        calc_model(cmd, op1, op2, er, ed);
        et = 1'b0;
        waits = delay;
        if (cmd == CMD_NOP) begin
            er = RESP_NONE;
            ed = 32'd0;
            waits = 0;
        end else if (TimeoutOn && (delay == 0 || delay > int'(TMO))) begin
            er = RESP_NONE;
            ed = 32'd0;
            et = 1'b1;
            waits = TMO;
        end

        check("idle_in_ready", 64'(in_ready), 64'd1);
        check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
        in_valid = 1'b1;
        in_cmd = cmd;
        in_op1 = op1;
        in_op2 = op2;
        tick();
        // Inputs after acceptance must not leak into the captured request.
        in_valid = 1'b0;
        in_cmd = 4'($urandom);
        in_op1 = $urandom;
        in_op2 = $urandom;
        // Junk responses outside WAIT_RESP must be ignored.
        out_resp = 2'($urandom_range(1, 3));
        out_data = $urandom;
        check("op1_cmd", 64'(req_cmd_out), 64'(cmd));
        check("op1_data", 64'(req_data_out), 64'(op1));
        check("op1_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("op2_cmd", 64'(req_cmd_out), 64'd0);
        check("op2_data", 64'(req_data_out), 64'(op2));
        tick();
        out_resp = RESP_NONE;
        for (int w = 1; w <= waits; w++) begin
            check("wait_req", {28'd0, req_cmd_out, req_data_out}, 64'd0);
            check("wait_rsp_valid", 64'(rsp_valid), 64'd0);
            if (!et && w == delay) begin
                out_resp = er;
                out_data = ed;
            end
            tick();
            out_resp = RESP_NONE;
            out_data = $urandom;
        end
        for (int h = 0; h <= hold; h++) begin
            check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            check("hold_rsp_resp", 64'(rsp_resp), 64'(er));
            check("hold_rsp_data", 64'(rsp_data), 64'(ed));
            check("hold_rsp_timeout", 64'(rsp_timeout), 64'(et));
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_req", {28'd0, req_cmd_out, req_data_out}, 64'd0);
            out_resp = 2'($urandom_range(1, 3));
            out_data = $urandom;
            rsp_ready = (h == hold);
            tick();
        end
        rsp_ready = 1'b0;
        out_resp = RESP_NONE;
        check("post_rsp_valid", 64'(rsp_valid), 64'd0);
        check("post_in_ready", 64'(in_ready), 64'd1);
    endtask

    // Accept a request and advance to the first WAIT_RESP cycle without checking.
    task automatic start_to_wait(input logic [3:0] cmd, input logic [31:0] op1,
                                 input logic [31:0] op2);
        in_valid = 1'b1;
        in_cmd = cmd;
        in_op1 = op1;
        in_op2 = op2;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic pulse_reset(input string pfx);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_vals(pfx);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_cmd = '0;
        in_op1 = '0;
        in_op2 = '0;
        out_resp = '0;
        out_data = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        check_reset_vals("reset");
        reset = 1'b0;
        tick();

        // Basic add, answered on the third WAIT_RESP cycle.
        do_txn(CMD_ADD, 32'h5, 32'h1, 3, 0);
        // No-op: straight to HOLD_RSP with an empty result.
        do_txn(CMD_NOP, 32'h64, 32'h27, 1, 0);
        // Overflow response passes through.
        do_txn(CMD_ADD, 32'hFFFF_FFFF, 32'h1, 2, 0);
        // Back-pressure for 5 cycles, then an immediate second request.
        do_txn(CMD_SUB, 32'h10, 32'h3, 1, 5);
        do_txn(CMD_SHL, 32'h1, 32'h4, 2, 0);
        do_txn(4'd9, 32'h7, 32'h7, 1, 0);

        // Randomised traffic.
        for (int i = 0; i < 24; i++) begin
            do_txn(4'($urandom_range(0, 15)), $urandom, $urandom,
                   TimeoutOn ? $urandom_range(1, 12) : $urandom_range(1, 4),
                   $urandom_range(0, 3));
        end

        // Silent calculator.
        if (TimeoutOn) begin
            do_txn(CMD_ADD, 32'h1, 32'h2, 0, 1);
            do_txn(CMD_ADD, 32'h3, 32'h4, TMO, 0);
        end else begin
            start_to_wait(CMD_ADD, 32'h1, 32'h2);
            for (int c = 0; c < 50; c++) begin
                check("nores_rsp_valid", 64'(rsp_valid), 64'd0);
                check("nores_in_ready", 64'(in_ready), 64'd0);
                tick();
            end
            pulse_reset("nores_reset");
        end

        // Reset during WAIT_RESP discards the transaction.
        do_txn(CMD_ADD, 32'h20, 32'h22, 1, 0);
        start_to_wait(CMD_ADD, 32'h8, 32'h9);
        tick();
        pulse_reset("wait_reset");
        for (int c = 0; c < 4; c++) begin
            out_resp = RESP_OK;
            out_data = 32'h11;
            tick();
            check("discard_rsp_valid", 64'(rsp_valid), 64'd0);
            check("discard_in_ready", 64'(in_ready), 64'd1);
        end
        out_resp = RESP_NONE;

        // Reset during HOLD_RSP also discards.
        start_to_wait(CMD_SUB, 32'h9, 32'h2);
        out_resp = RESP_OK;
        out_data = 32'h7;
        tick();
        out_resp = RESP_NONE;
        check("hold_before_reset", 64'(rsp_valid), 64'd1);
        pulse_reset("hold_reset");

        do_txn(CMD_SHR, 32'h80, 32'h3, 2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
